dma_rd_burst_gen: RTL and testbench
===================================

Name: dma_rd_burst_gen

Overview:
- AXI4 read-burst master that fetches feature-map/weight data from DRAM as fixed 16-beat INCR bursts.
- Converts the R channel into the beat stream consumed directly downstream by the BRAM write-address controller: data, valid, beat count with end-of-burst flag, and done pulse.
- Honours a hold request from downstream so that no new burst starts while the conv stage is draining.

Parameters:
- AXI_ADDR_WIDTH, 32, AR address width.
- AXI_DATA_WIDTH, 64, R data width; beat byte count = AXI_DATA_WIDTH/8.
- BURST_LEN, 16, beats per burst; fixed, ARLEN = BURST_LEN-1.
- NUM_BURST_WIDTH, 16, width of the burst-count request.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1.
- i_base_addr  in  AXI_ADDR_WIDTH  first burst address; sampled on accepted i_start.
- i_num_burst  in  NUM_BURST_WIDTH  number of bursts; sampled on accepted i_start.
- i_hold  in  1  downstream break; blocks the next AR issue.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse when all bursts are complete.
- o_err  out  1  sticky error (RRESP!=OKAY or RLAST misalignment); cleared on accepted i_start.
- o_araddr  out  AXI_ADDR_WIDTH  AR address.
- o_arlen  out  8  constant BURST_LEN-1.
- o_arsize  out  3  constant log2(AXI_DATA_WIDTH/8).
- o_arburst  out  2  constant 2'b01 (INCR).
- o_arvalid  out  1  AR valid.
- i_arready  in  1  AR ready.
- i_rdata  in  AXI_DATA_WIDTH  R data.
- i_rresp  in  2  R response.
- i_rlast  in  1  R last.
- i_rvalid  in  1  R valid.
- o_rready  out  1  R ready.
- o_rvalid  out  1  registered R handshake (i_rvalid & o_rready) delayed one cycle.
- o_read_data  out  AXI_DATA_WIDTH  registered beat data.
- o_read_data_vld  out  1  registered beat-valid strobe.
- o_read_data_cnt  out  8  beat index 0..15; value 16 (bit 4 set) marks burst end.
- o_read_done  out  1  one-cycle pulse, coincident with cnt=16.

Behaviour:
- Reset values: every output 0; o_arlen, o_arsize and o_arburst are constants. All internal counters 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE: accepted i_start → ADDR, or → DONE when i_num_burst=0.
  - ADDR: o_arvalid=1 and o_araddr is held stable until i_arready, then → DATA. o_arvalid never drops without a handshake.
  - DATA: o_rready=1. On each handshake the beat counter increments. On the 16th handshake → GAP.
  - GAP: exactly one cycle; the cnt=16 flag is visible on the outputs. If the remaining burst count is 0 → DONE; else if i_hold=1 → HOLD; else → ADDR.
  - HOLD: stays while i_hold=1; → ADDR the first cycle i_hold=0.
  - DONE: o_done=1 for one cycle, → IDLE.
- Output timing: a beat handshaken at cycle t appears at t+1 as o_read_data_vld=1, o_rvalid=1, o_read_data=beat, and o_read_data_cnt=index (0..15).
  - The cycle after index 15 is presented: cnt=16, vld=0, o_read_done=1.
  - The following cycle: cnt=0.
  - Between bursts, cnt stays 0 with vld=0.
  - Consumers use cnt[3:0] as the BRAM sub-address and cnt[4] as the burst-end flag.
- Address: increments by BURST_LEN*AXI_DATA_WIDTH/8 after each AR handshake; wraps modulo 2^AXI_ADDR_WIDTH. No 4 KB split; the caller aligns the base address.
- Outstanding transactions: exactly one burst at a time; the next AR is issued only after GAP.
- Burst end is count-based (16 beats).
  - i_rlast=1 on beats 0..14, or i_rlast=0 on beat 15 → o_err=1; the transfer continues.
  - Any i_rresp≠0 → o_err=1.
- Simultaneous events:
  - i_hold high on the final GAP → DONE; hold has no effect.
  - i_hold rising during DATA is not acted on until GAP.
  - i_start during busy is ignored (no queueing).
- Reset mid-operation: all state is cleared immediately. An AXI transaction in flight is abandoned; the interconnect is reset on the same reset net.

Optional Feature:
- Macro DMA_RD_STALL_CNT_EN.
- When defined, adds output o_stall_cnt (32 bits).
  - Counts cycles in ADDR with i_arready=0, plus cycles in DATA with i_rvalid=0.
  - Clears on accepted i_start and saturates at all-ones.
- When not defined, the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package aix_dma_pkg holds:
  - FSM state encodings.
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - Beat-count end-flag bit index (4).
- One sub-module: dma_rd_beat_reg.
  - Output register stage that generates o_read_data, o_read_data_vld, o_rvalid, o_read_data_cnt and o_read_done from handshake, beat index and GAP indication.
  - The top module keeps the FSM and address/burst counters.

Test Plan:
- Single burst, base 0x1000_0000, i_num_burst=1, zero-wait slave:
  - One AR, address 0x1000_0000, ARLEN=15.
  - cnt 0..15 with vld, then cnt=16 with o_read_done, then o_done one cycle later.
- i_num_burst=4, random R stalls: ARADDR sequence 0x..000, 0x..080, 0x..100, 0x..180; 64 vld pulses; 4 o_read_done pulses; the AR stall ordering follows the ADDR/DATA/GAP rules.
- i_hold=1 asserted mid-burst 2 of 3, released 20 cycles later:
  - Burst 2 completes.
  - No o_arvalid for 20 cycles.
  - Burst 3 AR appears the cycle after release.
- i_rresp=2'b10 on beat 5, plus i_rlast early on beat 9 of a later burst: o_err=1 sticky; beat count still reaches 16; o_done is asserted; the next i_start clears o_err.
- i_num_burst=0 → o_done one cycle after start with no AR. Separately, i_arready held low 10 cycles → o_arvalid and o_araddr stay stable throughout.
- i_rstn low during DATA at beat 7: all outputs 0 the same cycle; FSM in IDLE after release; a new start works normally.

Source files
------------

// File: rtl/aix_dma_pkg.sv
// -----------------------------------------------------------------------------
// aix_dma_pkg
// Shared definitions for the DMA read-burst generator:
//   - FSM state encoding of the burst sequencer
//   - AXI constants (INCR burst type, OKAY response)
//   - bit index of the burst-end flag in the downstream beat count
// -----------------------------------------------------------------------------
package aix_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_GAP  = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } dma_rd_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Downstream uses cnt[3:0] as BRAM sub-address and cnt[4] as burst end.
    localparam int CNT_END_BIT = 4;

endpackage

// File: rtl/dma_rd_beat_reg.sv
// -----------------------------------------------------------------------------
// dma_rd_beat_reg
// Output register stage for the R-channel beat stream handed to the BRAM
// write-address controller.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   hs_i            R handshake this cycle (i_rvalid & o_rready)
//   data_i          R data of the handshaken beat
//   idx_i           beat index of the handshaken beat (0..BURST_LEN-1)
//   gap_i           sequencer is in its one-cycle GAP state
//   data_o          registered beat data
//   vld_o           registered beat-valid strobe
//   rvalid_o        registered R handshake (same timing as vld_o)
//   cnt_o           beat index, or the end marker (bit CNT_END_BIT) after GAP
//   done_o          one-cycle pulse coincident with the end marker
// -----------------------------------------------------------------------------
module dma_rd_beat_reg
    import aix_dma_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hs_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [7:0]        idx_i,
    input  logic              gap_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    output logic              rvalid_o,
    output logic [7:0]        cnt_o,
    output logic              done_o
);

    localparam logic [7:0] CNT_END = 8'(1 << CNT_END_BIT);

    logic [DATA_W-1:0] data_q;
    logic              vld_q;
    logic [7:0]        cnt_q;
    logic              done_q;

    // The last beat is shown while the sequencer sits in GAP, so registering
    // gap_i puts the end marker exactly one cycle after index 15.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            vld_q  <= hs_i;
            done_q <= gap_i;
            if (hs_i) begin
                data_q <= data_i;
                cnt_q  <= idx_i;
            end else if (gap_i) begin
                cnt_q  <= CNT_END;
            end else begin
                cnt_q  <= '0;
            end
        end
    end

    assign data_o   = data_q;
    assign vld_o    = vld_q;
    assign rvalid_o = vld_q;
    assign cnt_o    = cnt_q;
    assign done_o   = done_q;

endmodule

// File: rtl/dma_rd_burst_gen.sv
// -----------------------------------------------------------------------------
// dma_rd_burst_gen
// AXI4 read-burst master: fetches i_num_burst fixed-length INCR bursts starting
// at i_base_addr, one burst outstanding at a time, and turns the R channel into
// a registered beat stream (data, valid, beat count with end flag, done pulse).
// A downstream hold blocks the next AR issue between bursts.
//
// Ports
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_start                start pulse (ignored while o_busy)
//   i_base_addr            first burst address (sampled on accepted start)
//   i_num_burst            number of bursts (sampled on accepted start)
//   i_hold                 downstream hold, blocks the next AR
//   o_busy, o_done         busy level / one-cycle completion pulse
//   o_err                  sticky RRESP / RLAST error, cleared on start
//   o_ar*, i_arready       AXI AR channel
//   i_r*, o_rready         AXI R channel
//   o_rvalid, o_read_data, o_read_data_vld, o_read_data_cnt, o_read_done
//                          registered beat stream for the BRAM writer
//   o_stall_cnt            (only with DMA_RD_STALL_CNT_EN) AR/R stall cycles
//
// Build option: define DMA_RD_STALL_CNT_EN to add the saturating stall counter.
// -----------------------------------------------------------------------------
module dma_rd_burst_gen
    import aix_dma_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int BURST_LEN       = 16,
    parameter int NUM_BURST_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [NUM_BURST_WIDTH-1:0] i_num_burst,
    input  logic                      i_hold,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err,
    output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    output logic                      o_rvalid,
    output logic [AXI_DATA_WIDTH-1:0] o_read_data,
    output logic                      o_read_data_vld,
    output logic [7:0]                o_read_data_cnt,
    output logic                      o_read_done
`ifdef DMA_RD_STALL_CNT_EN
    ,
    output logic [31:0]               o_stall_cnt
`endif
);

    localparam int                        BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC  =
        AXI_ADDR_WIDTH'(BURST_LEN * AXI_DATA_WIDTH / 8);

    dma_rd_state_e               state_q, state_d;
    logic                        arvalid_q, rready_q, busy_q, done_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_BURST_WIDTH-1:0]  rem_q, rem_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        err_q, err_d;

    logic ar_hs, r_hs, last_beat, start_acc;

    assign ar_hs     = arvalid_q & i_arready;
    assign r_hs      = rready_q & i_rvalid;
    assign last_beat = (beat_q == BEAT_LAST);
    assign start_acc = i_start & (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    addr_d  = i_base_addr;
                    rem_d   = i_num_burst;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = (i_num_burst == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // rem_q counts bursts not yet issued; it reaches 0 on the
                // final AR so GAP can decide on it directly.
                if (ar_hs) begin
                    addr_d  = addr_q + ADDR_INC;
                    rem_d   = rem_q - 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Burst end is decided by the beat count; RLAST is only
                // checked against it.
                if (r_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (i_rresp != RESP_OKAY) err_d = 1'b1;
                    if (i_rlast != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (rem_q == '0)  state_d = ST_DONE;
                else if (i_hold)  state_d = ST_HOLD;
                else              state_d = ST_ADDR;
            end
            ST_HOLD: begin
                if (!i_hold) state_d = ST_ADDR;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // AXI valid/ready are registered from the next state so they align with
    // state_q. o_done follows DONE by one cycle, landing just after the
    // burst-end marker; busy drops on that same cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= (state_d == ST_ADDR);
            rready_q  <= (state_d == ST_DATA);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_q == ST_DONE);
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_araddr  = addr_q;
    assign o_arlen   = 8'(BURST_LEN - 1);
    assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_arburst = BURST_INCR;
    assign o_arvalid = arvalid_q;
    assign o_rready  = rready_q;

    dma_rd_beat_reg #(
        .DATA_W (AXI_DATA_WIDTH)
    ) u_beat_reg (
        .clk_i    (i_clk),
        .rst_ni   (i_rstn),
        .hs_i     (r_hs),
        .data_i   (i_rdata),
        .idx_i    (8'(beat_q)),
        .gap_i    (state_q == ST_GAP),
        .data_o   (o_read_data),
        .vld_o    (o_read_data_vld),
        .rvalid_o (o_rvalid),
        .cnt_o    (o_read_data_cnt),
        .done_o   (o_read_done)
    );

`ifdef DMA_RD_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_ev;

    assign stall_ev = ((state_q == ST_ADDR) && !i_arready) ||
                      ((state_q == ST_DATA) && !i_rvalid);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (stall_ev && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dma_rd_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_burst_gen
// Directed bench for dma_rd_burst_gen: a procedural AXI slave feeds R beats
// whose data encodes burst address and beat index, and a negedge monitor
// tallies the downstream beat stream.
// -----------------------------------------------------------------------------
module tb_dma_rd_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_burst = '0;
    logic        hold = 1'b0;
    logic        busy, done, err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        rd_rvalid;
    logic [63:0] rd_data;
    logic        rd_vld;
    logic [7:0]  rd_cnt;
    logic        rd_done;
`ifdef DMA_RD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    // monitor state (written only by the monitor, except mon_clr/mon_base)
    logic        mon_clr = 1'b0;
    logic [31:0] mon_base = '0;
    int mon_vld, mon_rdone, mon_done, mon_ar, mon_bad, mon_beat, mon_burst;
    logic prev_rdone;

    always #5 clk = ~clk;

    dma_rd_burst_gen dut (
        .i_clk           (clk),
        .i_rstn          (rst_n),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_num_burst     (num_burst),
        .i_hold          (hold),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_araddr        (araddr),
        .o_arlen         (arlen),
        .o_arsize        (arsize),
        .o_arburst       (arburst),
        .o_arvalid       (arvalid),
        .i_arready       (arready),
        .i_rdata         (rdata),
        .i_rresp         (rresp),
        .i_rlast         (rlast),
        .i_rvalid        (rvalid),
        .o_rready        (rready),
        .o_rvalid        (rd_rvalid),
        .o_read_data     (rd_data),
        .o_read_data_vld (rd_vld),
        .o_read_data_cnt (rd_cnt),
        .o_read_done     (rd_done)
`ifdef DMA_RD_STALL_CNT_EN
        ,
        .o_stall_cnt     (stall_cnt)
`endif
    );

    function automatic logic [63:0] beat_word(input logic [31:0] addr, input int beat);
        return {addr, 32'hA5A5_0000 + 32'(beat)};
    endfunction

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_vld = 0; mon_rdone = 0; mon_done = 0; mon_ar = 0;
            mon_bad = 0; mon_beat = 0; mon_burst = 0; prev_rdone = 1'b0;
        end else begin
            if (arvalid && arready) mon_ar++;
            if (rd_vld) begin
                if (rd_data !== beat_word(mon_base + 32'(mon_burst * 128), mon_beat) ||
                    rd_cnt !== 8'(mon_beat) || rd_rvalid !== 1'b1)
                    mon_bad++;
                mon_beat++;
                mon_vld++;
            end
            if (rd_done) begin
                if (rd_cnt !== 8'd16 || rd_vld !== 1'b0 || mon_beat != 16) mon_bad++;
                mon_rdone++;
                mon_beat = 0;
                mon_burst++;
            end
            if (!rd_vld && !rd_done && rd_cnt !== 8'd0) mon_bad++;
            if (prev_rdone && rd_cnt !== 8'd0) mon_bad++;
            if (done) mon_done++;
            prev_rdone = rd_done;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [15:0] nb);
        mon_clr  = 1'b1;
        mon_base = base;
        tick();
        mon_clr   = 1'b0;
        start     = 1'b1;
        base_addr = base;
        num_burst = nb;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin tick(); n++; end
        check("done_seen", 64'(done), 64'd1);
    endtask

    // Serves one AR + 16 R beats; returns one tick after the last R handshake.
    task automatic slave_burst(input logic [31:0] addr, input int stall, input int ar_wait,
                               input int bad_resp, input int bad_last, input int hold_beat);
        int n = 0;
        logic stable = 1'b1;
        logic hs;
        while (!arvalid && n < 300) begin tick(); n++; end
        check("ar_seen", 64'(arvalid), 64'd1);
        check("araddr", 64'(araddr), 64'(addr));
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            if (!arvalid || araddr !== addr) stable = 1'b0;
        end
        if (ar_wait > 0) check("ar_stable", 64'(stable), 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            rvalid = 1'b0;
            if (stall != 0) repeat ((b * 7 + int'(addr[9:7])) % 3) tick();
            rvalid = 1'b1;
            rdata  = beat_word(addr, b);
            rresp  = (b == bad_resp) ? 2'b10 : 2'b00;
            rlast  = (b == 15) ^ (b == bad_last);
            if (b == hold_beat) hold = 1'b1;
            n = 0;
            do begin
                hs = rready;
                tick();
                n++;
            end while (!hs && n < 100);
            if (!hs) check("r_handshake", 64'(hs), 64'd1);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        int ar_seen;
        #2 rst_n = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_vld", 64'(rd_vld), 64'd0);
        check("rst_cnt", 64'(rd_cnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("arlen", 64'(arlen), 64'd15);
        check("arsize", 64'(arsize), 64'd3);
        check("arburst", 64'(arburst), 64'd1);
`ifdef DMA_RD_STALL_CNT_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // single burst, zero-wait slave
        start_run(32'h1000_0000, 16'd1);
        check("t1_busy", 64'(busy), 64'd1);
        slave_burst(32'h1000_0000, 0, 0, -1, -1, -1);
        check("t1_cnt15", 64'(rd_cnt), 64'd15);
        check("t1_vld15", 64'(rd_vld), 64'd1);
        tick();
        check("t1_cnt16", 64'(rd_cnt), 64'd16);
        check("t1_rdone", 64'(rd_done), 64'd1);
        check("t1_vld_end", 64'(rd_vld), 64'd0);
        check("t1_done_early", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_cnt0", 64'(rd_cnt), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_ar_cnt", 64'(mon_ar), 64'd1);
        check("t1_vld_cnt", 64'(mon_vld), 64'd16);
        check("t1_rdone_cnt", 64'(mon_rdone), 64'd1);
        check("t1_stream", 64'(mon_bad), 64'd0);

        // four bursts with R stalls, AR only after GAP
        start_run(32'h2000_0000, 16'd4);
        for (int k = 0; k < 4; k++) begin
            slave_burst(32'h2000_0000 + 32'(k * 128), 1, 0, -1, -1, -1);
            if (k < 3) begin
                check("t2_no_ar_gap", 64'(arvalid), 64'd0);
                tick();
                check("t2_ar_after_gap", 64'(arvalid), 64'd1);
            end
        end
        wait_done();
        tick();
        check("t2_vld_cnt", 64'(mon_vld), 64'd64);
        check("t2_rdone_cnt", 64'(mon_rdone), 64'd4);
        check("t2_ar_cnt", 64'(mon_ar), 64'd4);
        check("t2_done_cnt", 64'(mon_done), 64'd1);
        check("t2_stream", 64'(mon_bad), 64'd0);
        check("t2_err", 64'(err), 64'd0);

        // hold during burst 2 of 3, released 20 cycles after it ends
        start_run(32'h3000_0000, 16'd3);
        slave_burst(32'h3000_0000, 0, 0, -1, -1, -1);
        slave_burst(32'h3000_0080, 0, 0, -1, -1, 5);
        check("t3_burst2_end", 64'(rd_cnt), 64'd15);
        ar_seen = 0;
        repeat (20) begin
            if (arvalid) ar_seen++;
            tick();
        end
        check("t3_no_ar_hold", 64'(ar_seen), 64'd0);
        hold = 1'b0;
        tick();
        check("t3_ar_release", 64'(arvalid), 64'd1);
        slave_burst(32'h3000_0100, 0, 0, -1, -1, -1);
        wait_done();
        check("t3_rdone_cnt", 64'(mon_rdone), 64'd3);
        check("t3_stream", 64'(mon_bad), 64'd0);
        tick();

        // RRESP error, early RLAST, missing RLAST
        start_run(32'h4000_0000, 16'd1);
        slave_burst(32'h4000_0000, 0, 0, 5, -1, -1);
        wait_done();
        check("t4_err_resp", 64'(err), 64'd1);
        check("t4_rdone_cnt", 64'(mon_rdone), 64'd1);
        tick();
        start_run(32'h4000_1000, 16'd2);
        check("t4_err_clr", 64'(err), 64'd0);
        slave_burst(32'h4000_1000, 0, 0, -1, -1, -1);
        check("t4_err_clean", 64'(err), 64'd0);
        slave_burst(32'h4000_1080, 0, 0, -1, 9, -1);
        wait_done();
        check("t4_err_early_last", 64'(err), 64'd1);
        check("t4_rdone2", 64'(mon_rdone), 64'd2);
        check("t4_stream", 64'(mon_bad), 64'd0);
        tick();
        start_run(32'h4000_2000, 16'd1);
        slave_burst(32'h4000_2000, 0, 0, -1, 15, -1);
        wait_done();
        check("t4_err_no_last", 64'(err), 64'd1);
        tick();

        // zero bursts, then AR held off for 10 cycles
        start_run(32'h5000_0000, 16'd0);
        check("t5_busy", 64'(busy), 64'd1);
        check("t5_no_done_yet", 64'(done), 64'd0);
        tick();
        check("t5_done", 64'(done), 64'd1);
        check("t5_busy_end", 64'(busy), 64'd0);
        tick();
        check("t5_done_pulse", 64'(done), 64'd0);
        check("t5_no_ar", 64'(mon_ar), 64'd0);
        start_run(32'h5000_0100, 16'd1);
        slave_burst(32'h5000_0100, 0, 10, -1, -1, -1);
        wait_done();
        check("t5_stream", 64'(mon_bad), 64'd0);
        tick();

        // reset at beat 7 of a burst
        start_run(32'h6000_0000, 16'd2);
        ar_seen = 0;
        while (!arvalid && ar_seen < 50) begin tick(); ar_seen++; end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            rvalid = 1'b1;
            rdata  = beat_word(32'h6000_0000, b);
            rlast  = 1'b0;
            tick();
        end
        rdata  = beat_word(32'h6000_0000, 7);
        check("t6_pre_vld", 64'(rd_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_arvalid", 64'(arvalid), 64'd0);
        check("t6_rready", 64'(rready), 64'd0);
        check("t6_vld", 64'(rd_vld), 64'd0);
        check("t6_rvalid", 64'(rd_rvalid), 64'd0);
        check("t6_cnt", 64'(rd_cnt), 64'd0);
        check("t6_data", rd_data, 64'd0);
        check("t6_araddr", 64'(araddr), 64'd0);
        rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_idle", 64'(busy), 64'd0);
        start_run(32'h6000_0800, 16'd1);
        slave_burst(32'h6000_0800, 0, 0, -1, -1, -1);
        wait_done();
        check("t6_vld_cnt", 64'(mon_vld), 64'd16);
        check("t6_rdone_cnt", 64'(mon_rdone), 64'd1);
        check("t6_stream", 64'(mon_bad), 64'd0);
        check("t6_err", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
